fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted at the clock edge).
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address, word aligned.
REQ-007 imem_ready  input  1  memory accepts request this cycle (req & ready = accepted).
REQ-008 imem_rvalid  input  1  read data valid; at most one response per accepted request, in order, earliest one cycle after acceptance.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 instr_valid  output  1  buffer head holds an instruction for the decoder.
REQ-011 instr  output  32  head instruction (decoder takes Op=instr[27:26], Funct=instr[25:20], Rd=instr[15:12]).
REQ-012 instr_pc  output  32  address of head instruction.
REQ-013 pc_plus8  output  32  instr_pc + 8 (ARM PC read value), modulo 2^32.
REQ-014 dec_ready  input  1  decoder consumes head this cycle (pop = instr_valid & dec_ready).
REQ-015 redirect  input  1  taken branch (decoder PCS qualified by condition logic).
REQ-016 redirect_pc  input  32  branch target; bits [1:0] ignored, forced to 0.

Function
REQ-017 Controller states: IDLE (nothing outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded); at most one request outstanding.
REQ-018 fetch_pc register drives imem_addr; it increments by 4 (wrapping at 2^32) on each accepted request.
REQ-019 imem_req = !redirect & (IDLE | (WAIT & imem_rvalid)) & (count + (state==WAIT) - pop < DEPTH), where count is buffer occupancy.
REQ-020 imem_req may drop before acceptance only during a redirect cycle; otherwise, once asserted, it and imem_addr hold until imem_ready.
REQ-021 IDLE -> WAIT on acceptance; WAIT & imem_rvalid -> push {imem_rdata, pc of request} into buffer, then WAIT if a new request is accepted the same cycle, else IDLE.
REQ-022 DROP & imem_rvalid -> response discarded, no push, -> IDLE; imem_req is low in DROP.
REQ-023 Buffer is a registered FIFO: a pushed instruction appears on instr/instr_valid the cycle after imem_rvalid; simultaneous push and pop allowed at any occupancy, including full.
REQ-024 Outputs instr, instr_pc, pc_plus8 are stable while instr_valid=1 and no pop.
REQ-025 redirect has priority over all other events: buffer flushed (count<=0, instr_valid=0 next cycle), pop ignored, fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-026 On redirect: state -> DROP if in WAIT without imem_rvalid; otherwise -> IDLE (any imem_rvalid that cycle is discarded).
REQ-027 Next request after redirect is issued the following cycle (from IDLE) or after the dropped response (from DROP), at the target address.
REQ-028 With imem_ready=1, one-cycle response latency, and dec_ready=1, sustained throughput is one instruction per cycle.
REQ-029 Pushes never exceed DEPTH entries; pops never occur when empty.

Reset
REQ-030 While reset=0 at a clock edge: state=IDLE, fetch_pc=RESET_PC, count=0, read/write pointers=0, instr_valid=0, imem_req=0 during reset; buffer data not reset.
REQ-031 Reset asserted mid-operation abandons any outstanding request; a response arriving after reset release with state IDLE is ignored.
REQ-032 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-033 Reset release, imem_ready=1, one-cycle memory, dec_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; first instr_valid 2 cycles after first acceptance with instr_pc=0, pc_plus8=8.
REQ-034 dec_ready=0 with DEPTH=2 -> exactly 2 instructions buffered, imem_req=0 afterward; dec_ready=1 -> fetching resumes at next sequential address, no loss or duplicate.
REQ-035 imem_ready held 0 for 3 cycles -> imem_req=1 and imem_addr constant throughout; accepted on 4th cycle.
REQ-036 redirect to 32'h0000_0103 while in WAIT, response 2 cycles later -> response dropped, buffer empty, next imem_addr=32'h0000_0100, first new instr_pc=32'h100.
REQ-037 redirect in the same cycle as imem_rvalid and pop with full buffer -> nothing pushed, instr_valid=0 next cycle, next request at target.
REQ-038 reset=0 asserted while in DROP -> after release imem_addr=RESET_PC, late rvalid ignored, instr_valid remains 0 until the new response.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch controller with a small registered instruction buffer.
// Issues one word-aligned fetch at a time, queues returned words with their PCs and
// hands the oldest one to the decoder. A taken branch flushes the buffer, drops any
// response still in flight and restarts fetching at the branch target.
//
// Ports
//   clk, reset                    clock; synchronous active-low reset
//   imem_req/addr/ready           fetch request handshake (req & ready = accepted)
//   imem_rvalid/rdata             in-order read response, at most one per request
//   instr_valid/instr/instr_pc    buffer head presented to the decoder
//   pc_plus8                      instr_pc + 8 (architectural PC read value)
//   dec_ready                     decoder consumes the head this cycle
//   redirect/redirect_pc          taken branch and its target
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus8,
   input  logic        dec_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic [31:0]     buf_data [DEPTH];
   logic [31:0]     buf_pc   [DEPTH];

   logic            pop_raw, pop, push, accept, in_wait;
   logic [AW+1:0]   slots;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign in_wait     = (state_q == StWait);
   assign instr_valid = (count_q != '0);
   assign pop_raw     = instr_valid & dec_ready;
   assign pop         = pop_raw & ~redirect;
   assign push        = in_wait & imem_rvalid & ~redirect;

   // Occupancy once the in-flight word lands and this cycle's pop is taken.
   assign slots = {1'b0, count_q} + (AW+2)'(in_wait) - (AW+2)'(pop_raw);

   assign imem_req  = reset & ~redirect & ((state_q == StIdle) | (in_wait & imem_rvalid)) &
                      (slots < (AW+2)'(DEPTH));
   assign imem_addr = fetch_pc_q;
   assign accept    = imem_req & imem_ready;

   assign instr    = buf_data[rd_ptr_q];
   assign instr_pc = buf_pc[rd_ptr_q];
   assign pc_plus8 = instr_pc + 32'd8;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // Anything still owed by memory must be swallowed before the next request,
         // so a pending response (WAIT or DROP) keeps us in DROP.
         state_d = ((state_q != StIdle) && !imem_rvalid) ? StDrop : StIdle;
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
         unique case (state_q)
            StIdle:  if (accept) state_d = StWait;
            StWait:  if (imem_rvalid) state_d = accept ? StWait : StIdle;
            StDrop:  if (imem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if (redirect) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
         end
      end
   end

   // Data storage is not reset. A pushed word always belongs to the single outstanding
   // request, whose address is one word behind fetch_pc (fetch_pc advanced on accept
   // and cannot move again until the response returns or a redirect drops it).
   always_ff @(posedge clk) begin
      if (reset && push) begin
         buf_data[wr_ptr_q] <= imem_rdata;
         buf_pc[wr_ptr_q]   <= fetch_pc_q - 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle bench for fetch_unit with a simple memory model
// of programmable latency. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus8;
   logic        dec_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int n_chk = 0;
   int n_bad = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .pc_plus8    (pc_plus8),
      .dec_ready   (dec_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hE000_0000 ^ {a[15:0], a[15:0]};
   endfunction

   // Memory model: a request accepted at an edge answers `lat` cycles later.
   int          lat = 1;
   logic        pv = 1'b0;
   int          pcnt = 0;
   logic [31:0] pa = 32'h0;
   logic        rv_n;
   logic [31:0] ra;

   always @(posedge clk) begin
      rv_n = 1'b0;
      ra   = 32'h0;
      if (pv) begin
         pcnt = pcnt - 1;
         if (pcnt == 0) begin
            rv_n = 1'b1;
            ra   = pa;
            pv   = 1'b0;
         end
      end
      if (imem_req && imem_ready) begin
         if (lat <= 1) begin
            rv_n = 1'b1;
            ra   = imem_addr;
         end else begin
            pv   = 1'b1;
            pcnt = lat - 1;
            pa   = imem_addr;
         end
      end
      #1;
      imem_rvalid = rv_n;
      imem_rdata  = rv_n ? word(ra) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic exp_fetch(input string tag, input logic req, input logic [31:0] addr);
      check({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
      if (req) check({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic exp_head(input string tag, input logic v, input logic [31:0] pc);
      check({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
      if (v) begin
         check({tag, ".pc"}, instr_pc, pc);
         check({tag, ".instr"}, instr, word(pc));
         check({tag, ".pc8"}, pc_plus8, pc + 32'd8);
      end
   endtask

   initial begin
      reset       = 1'b0;
      imem_ready  = 1'b1;
      dec_ready   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      nxt(); nxt();
      smp();
      exp_fetch("rst", 1'b0, 32'h0);
      exp_head("rst", 1'b0, 32'h0);

      // Streaming from RESET_PC: one request per cycle, head trails by two cycles.
      nxt();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) nxt();
         smp();
         exp_fetch("stream", 1'b1, 32'(4 * k));
         exp_head("stream", (k >= 2), 32'(4 * (k - 2)));
      end

      // Decoder stalls: two words fill the buffer, then fetching stops.
      nxt();
      dec_ready = 1'b0;
      smp();
      exp_fetch("stall", 1'b0, 32'h0);
      exp_head("stall", 1'b1, 32'd16);
      repeat (3) begin
         nxt(); smp();
         exp_fetch("full", 1'b0, 32'h0);
         exp_head("full", 1'b1, 32'd16);
      end
      nxt();
      dec_ready = 1'b1;
      smp();
      exp_fetch("resume", 1'b1, 32'd24);
      exp_head("resume", 1'b1, 32'd16);
      nxt(); smp();
      exp_fetch("resume1", 1'b1, 32'd28);
      exp_head("resume1", 1'b1, 32'd20);
      nxt(); smp();
      exp_fetch("resume2", 1'b1, 32'd32);
      exp_head("resume2", 1'b1, 32'd24);

      // Memory not ready for three cycles: request and address hold.
      nxt();
      imem_ready = 1'b0;
      smp();
      exp_fetch("busy0", 1'b1, 32'd36);
      exp_head("busy0", 1'b1, 32'd28);
      nxt(); smp();
      exp_fetch("busy1", 1'b1, 32'd36);
      exp_head("busy1", 1'b1, 32'd32);
      nxt(); smp();
      exp_fetch("busy2", 1'b1, 32'd36);
      exp_head("busy2", 1'b0, 32'h0);
      nxt();
      imem_ready = 1'b1;
      smp();
      exp_fetch("accept", 1'b1, 32'd36);
      nxt(); smp();
      exp_fetch("after_acc", 1'b1, 32'd40);
      exp_head("after_acc", 1'b0, 32'h0);

      // Redirect while waiting; the old response comes back two cycles later.
      nxt();
      lat = 3;
      smp();
      exp_fetch("pre_br", 1'b1, 32'd44);
      exp_head("pre_br", 1'b1, 32'd36);
      nxt();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      smp();
      exp_fetch("br_wait", 1'b0, 32'h0);
      nxt();
      redirect = 1'b0;
      smp();
      exp_fetch("drop0", 1'b0, 32'h0);
      exp_head("drop0", 1'b0, 32'h0);
      nxt(); smp();
      exp_fetch("drop1", 1'b0, 32'h0);
      exp_head("drop1", 1'b0, 32'h0);
      nxt();
      lat = 1;
      smp();
      exp_fetch("tgt0", 1'b1, 32'h0000_0100);
      exp_head("tgt0", 1'b0, 32'h0);
      nxt(); smp();
      exp_fetch("tgt1", 1'b1, 32'h0000_0104);
      exp_head("tgt1", 1'b0, 32'h0);
      nxt(); smp();
      exp_fetch("tgt2", 1'b1, 32'h0000_0108);
      exp_head("tgt2", 1'b1, 32'h0000_0100);

      // Redirect coinciding with a response and a pop: nothing is pushed.
      nxt();
      redirect    = 1'b1;
      redirect_pc = 32'h2000_0042;
      smp();
      exp_fetch("br_rv", 1'b0, 32'h0);
      exp_head("br_rv", 1'b1, 32'h0000_0104);
      nxt();
      redirect = 1'b0;
      smp();
      exp_fetch("flush0", 1'b1, 32'h2000_0040);
      exp_head("flush0", 1'b0, 32'h0);
      nxt(); smp();
      exp_fetch("flush1", 1'b1, 32'h2000_0044);
      exp_head("flush1", 1'b0, 32'h0);

      // Reset while dropping a response; the late response must be ignored.
      nxt();
      lat = 3;
      smp();
      exp_fetch("hi_tgt", 1'b1, 32'h2000_0048);
      exp_head("hi_tgt", 1'b1, 32'h2000_0040);
      nxt();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      smp();
      exp_fetch("br2", 1'b0, 32'h0);
      nxt();
      redirect = 1'b0;
      reset    = 1'b0;
      smp();
      exp_fetch("rst_drop", 1'b0, 32'h0);
      exp_head("rst_drop", 1'b0, 32'h0);
      nxt();
      reset = 1'b1;
      lat   = 1;
      smp();
      exp_fetch("rel0", 1'b1, 32'h0);
      exp_head("rel0", 1'b0, 32'h0);
      nxt(); smp();
      exp_fetch("rel1", 1'b1, 32'h4);
      exp_head("rel1", 1'b0, 32'h0);
      nxt(); smp();
      exp_fetch("rel2", 1'b1, 32'h8);
      exp_head("rel2", 1'b1, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
